// File: rtl/ccff_pkg.sv
// Shared types and fabric constants for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int unsigned FABRIC_CHAIN_LEN = 1024;

endpackage

// File: rtl/ccff_phase_gen.sv
// Counts CLK_DIV cycles per prog_clk phase and strobes the last cycle of each phase.
module ccff_phase_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last        = (cnt == CW'(CLK_DIV - 1));
  assign phase_end_c = run && last;

  // Counter restarts whenever the shifter is not in a clock phase.
  always_ff @(posedge clk) begin
    if (reset || !run || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Streams a byte-wide bitstream into the OpenFPGA configuration chain,
// generating prog_clk, set and the fabric user reset.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = FABRIC_CHAIN_LEN,
  parameter int unsigned SET_CYCLES = 4,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     cfg_data,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  output logic                           prog_clk,
  output logic                           set,
  output logic                           ccff_head,
  input  logic                           ccff_tail,
  output logic                           fabric_reset,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count,
  output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned SET_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  state_t           state;
  state_t           state_next;
  logic [SET_W-1:0] set_cnt;
  logic [7:0]       shreg;
  logic [3:0]       bits_left;
  logic             phase_end_c;
  logic             take_byte_c;
  logic             rise_c;

  ccff_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_gen (
    .clk        (clk),
    .reset      (reset),
    .run        ((state == LOW) || (state == HIGH)),
    .phase_end_c(phase_end_c)
  );

  assign take_byte_c = (state == FETCH) && cfg_valid;
  assign rise_c      = (state == LOW) && phase_end_c;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = CLEAR;
      CLEAR: if (set_cnt == SET_W'(SET_CYCLES - 1)) state_next = FETCH;
      FETCH: if (cfg_valid) state_next = LOW;
      LOW:   if (phase_end_c) state_next = HIGH;
      HIGH: begin
        if (phase_end_c) begin
          if (bit_count == CNT_W'(CHAIN_LEN)) begin
            state_next = DONE;
          end else if (bits_left == 4'd0) begin
            state_next = FETCH;
          end else begin
            state_next = LOW;
          end
        end
      end
      DONE:    if (start) state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      set_cnt      <= '0;
      shreg        <= '0;
      bits_left    <= '0;
      bit_count    <= '0;
      tail_ones    <= '0;
      prog_clk     <= 1'b0;
      set          <= 1'b0;
      ccff_head    <= 1'b0;
      cfg_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fabric_reset <= 1'b1;
    end else begin
      state        <= state_next;
      prog_clk     <= (state_next == HIGH);
      set          <= (state_next == CLEAR);
      cfg_ready    <= (state_next == FETCH);
      busy         <= (state_next != IDLE) && (state_next != DONE);
      done         <= (state_next == DONE);
      fabric_reset <= (state_next != DONE);
      set_cnt      <= (state == CLEAR) ? set_cnt + SET_W'(1) : '0;

      if ((state_next == CLEAR) && (state != CLEAR)) begin
        bit_count <= '0;
        tail_ones <= '0;
      end

      if (take_byte_c) begin
        shreg     <= cfg_data;
        bits_left <= 4'd8;
        ccff_head <= cfg_data[7];
      end

      // Bit is committed on the prog_clk rise; the tail is sampled there too.
      if (rise_c) begin
        shreg     <= {shreg[6:0], 1'b0};
        bits_left <= bits_left - 4'd1;
        bit_count <= bit_count + CNT_W'(1);
        tail_ones <= tail_ones + CNT_W'(ccff_tail);
      end

      if ((state == HIGH) && (state_next == LOW)) begin
        ccff_head <= shreg[7];
      end
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Randomized bench for ccff_loader: two instances (12-bit/div 1 and 8-bit/div 3)
// checked against a bit-sequence and timing model derived from the byte stream.
module tb_ccff_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       ccff_tail;
  logic       sel;

  logic       a_ready, a_pc, a_set, a_head, a_frst, a_busy, a_done;
  logic [3:0] a_bc, a_to;
  logic       b_ready, b_pc, b_set, b_head, b_frst, b_busy, b_done;
  logic [3:0] b_bc, b_to;

  logic       start_a, start_b;
  logic       o_ready, o_pc, o_set, o_head, o_frst, o_busy, o_done;
  logic [3:0] o_bc, o_to;

  int n_checks = 0;
  int n_errors = 0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_pc    = sel ? b_pc    : a_pc;
  assign o_set   = sel ? b_set   : a_set;
  assign o_head  = sel ? b_head  : a_head;
  assign o_frst  = sel ? b_frst  : a_frst;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_bc    = sel ? b_bc    : a_bc;
  assign o_to    = sel ? b_to    : a_to;

  ccff_loader #(.CHAIN_LEN(12), .SET_CYCLES(4), .CLK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(a_ready), .prog_clk(a_pc), .set(a_set),
    .ccff_head(a_head), .ccff_tail(ccff_tail), .fabric_reset(a_frst),
    .busy(a_busy), .done(a_done), .bit_count(a_bc), .tail_ones(a_to)
  );

  ccff_loader #(.CHAIN_LEN(8), .SET_CYCLES(4), .CLK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(b_ready), .prog_clk(b_pc), .set(b_set),
    .ccff_head(b_head), .ccff_tail(ccff_tail), .fabric_reset(b_frst),
    .busy(b_busy), .done(b_done), .bit_count(b_bc), .tail_ones(b_to)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, 32'({o_pc, o_set, o_head, o_ready, o_busy, o_done, o_frst}), 32'b0000001);
    check({tag, "_bc"}, 32'(o_bc), 32'd0);
    check({tag, "_to"}, 32'(o_to), 32'd0);
  endtask

  // gap_mode: 0 back-to-back, 1 five idle cycles after first byte, 2 random valid.
  task automatic run_load(input string tag, input int n_bits, input int div, input int gap_mode,
                          input logic tail, input int abort_rise, input bit busy_start);
    int         nbytes;
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [31:0] exp_word, got_word;
    int cyc, idx, accepted, rises, set_cyc, viol, gap_left, head_age, hi_run, last_rise;
    bit finished, prev_pc, prev_head, gap_armed;

    nbytes = (n_bits + 7) / 8;
    for (int i = 0; i <= nbytes; i++) bytes.push_back(8'($urandom));
    exp_word = '0;
    for (int i = 0; i < n_bits; i++) begin
      b = bytes[i / 8];
      exp_word = {exp_word[30:0], b[7 - (i % 8)]};
    end

    @(negedge clk);
    start = 1'b1; ccff_tail = tail; cfg_valid = 1'b0;
    cyc = 0; idx = 0; accepted = 0; rises = 0; set_cyc = 0; viol = 0; gap_left = 0;
    head_age = 0; hi_run = 0; last_rise = 0; finished = 0; gap_armed = 0;
    prev_pc = o_pc; prev_head = o_head; got_word = '0;

    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (o_set) set_cyc++;
      if (o_pc && (o_set || o_ready)) viol++;
      head_age = (o_head != prev_head) ? 1 : head_age + 1;
      if (o_pc && (o_head != prev_head)) viol++;
      if (o_pc) hi_run++;
      if (!o_pc && prev_pc) begin
        if (hi_run != div) viol++;
        hi_run = 0;
      end
      if (o_pc && !prev_pc) begin
        got_word = {got_word[30:0], o_head};
        rises++;
        if (head_age < div + 1) viol++;
        if (nbytes == 1 && rises > 1 && (cyc - last_rise) != 2 * div) viol++;
        last_rise = cyc;
        if (abort_rise != 0 && rises == abort_rise) begin
          reset = 1'b1;
          cfg_valid = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          check({tag, "_abort_pc_set"}, 32'({o_pc, o_set}), 32'd0);
          check({tag, "_abort_busy"}, 32'(o_busy), 32'd0);
          check({tag, "_abort_frst"}, 32'(o_frst), 32'd1);
          check({tag, "_abort_bc"}, 32'(o_bc), 32'd0);
          return;
        end
      end
      prev_pc = o_pc;
      prev_head = o_head;
      if (o_done) begin
        finished = 1;
        break;
      end
      if (busy_start && cyc == 10) start = 1'b1;

      if (gap_mode == 1 && gap_left > 0) begin
        cfg_valid = 1'b0;
        gap_left--;
      end else if (gap_mode == 2) begin
        cfg_valid = (idx < bytes.size()) && ($urandom_range(0, 2) != 0);
      end else begin
        cfg_valid = (idx < bytes.size());
      end
      if (idx < bytes.size()) cfg_data = bytes[idx];
      if (cfg_valid && o_ready) begin
        accepted++;
        idx++;
        if (gap_mode == 1 && !gap_armed) begin
          gap_armed = 1;
          gap_left = 5;
        end
      end
    end
    cfg_valid = 1'b0;

    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_set_cycles"}, 32'(set_cyc), 32'd4);
    check({tag, "_bytes"}, 32'(accepted), 32'(nbytes));
    check({tag, "_rises"}, 32'(rises), 32'(n_bits));
    check({tag, "_head_seq"}, got_word, exp_word);
    check({tag, "_timing"}, 32'(viol), 32'd0);
    check({tag, "_done_frst_busy"}, 32'({o_done, o_frst, o_busy}), 32'b100);
    check({tag, "_bit_count"}, 32'(o_bc), 32'(n_bits));
    check({tag, "_tail_ones"}, 32'(o_to), tail ? 32'(n_bits) : 32'd0);
    if (gap_mode == 0)
      check({tag, "_load_time"}, 32'(cyc), 32'(1 + 4 + nbytes + n_bits * 2 * div));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_data = '0; cfg_valid = 1'b0; ccff_tail = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst_a");
    sel = 1'b1;
    check_reset_state("rst_b");
    sel = 1'b0;
    reset = 1'b0;

    run_load("a_b2b_tail1", 12, 1, 0, 1'b1, 0, 1'b0);
    run_load("a_gap_tail0", 12, 1, 1, 1'b0, 0, 1'b0);
    run_load("a_busy_start", 12, 1, 0, 1'($urandom), 0, 1'b1);
    run_load("a_abort", 12, 1, 0, 1'b1, 6, 1'b0);
    check_reset_state("a_after_abort");
    run_load("a_reload", 12, 1, 0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_load("a_rand", 12, 1, 2, 1'($urandom), 0, 1'($urandom));

    sel = 1'b1;
    run_load("b_b2b", 8, 3, 0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 2; k++)
      run_load("b_rand", 8, 3, 2, 1'($urandom), 0, 1'($urandom));

    // start and reset together: reset must win.
    @(negedge clk);
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("b_start_vs_reset", 32'({o_busy, o_set, o_done, o_frst}), 32'b0001);
    @(negedge clk);
    check("b_stays_idle", 32'({o_busy, o_set}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
